aes_cipher_iter: RTL and testbench
==================================

// Module: aes_cipher_iter
// PURPOSE
//  Iterative AES encryption core: one round per clock over a pre-expanded key schedule.
//  Forward counterpart of the iterative decipher core. Sits between the key-expansion
//  block and the block-mode/datapath wrapper.
//  Start/ready/done handshake: the host launches one block at a time, and the result
//  is held until the next completion.
// PARAMETERS
//  N   128  key length in bits (128/192/256)
//  Nk  4    key length in 32-bit words (N/32)
//  Nr  10   number of rounds (Nk+6); fixes key-schedule width = 128*(Nr+1)
// PORTS
//  clk    in   1            single clock; all state updates on posedge
//  rst    in   1            synchronous, active-high reset
//  start  in   1            launch request; accepted only when ready=1
//  in     in   128          plaintext; in[127:120] = state byte 0, column-major (FIPS-197)
//  word   in   128*(Nr+1)   expanded key schedule; round key r = word[128*r +: 128]
//  ready  out  1            core idle, start will be accepted this cycle
//  out    out  128          ciphertext, registered, same byte order as in
//  done   out  1            one-cycle pulse: out holds a new valid ciphertext
// BEHAVIOUR
//  - Reset (rst=1 at posedge): FSM->IDLE, round counter=0, state reg=0, out=0, done=0;
//    ready=1 in the first cycle after reset. rst has priority over start.
//  - FSM states: IDLE, ROUND.
//  - IDLE
//    - start=1 at edge E0: state <= in ^ word[127:0]; cnt <= 1; go to ROUND.
//    - start=0: remain in IDLE.
//  - ROUND, cnt in 1..Nr-1:
//    state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[cnt]; cnt <= cnt+1.
//  - ROUND, cnt==Nr (final round, no MixColumns):
//    - out <= ShiftRows(SubBytes(state)) ^ rk[Nr]; done <= 1; go to IDLE.
//  - Latency: done=1 in the cycle after edge E0+Nr (10 edges after the accept edge when
//    Nr=10). Throughput: one block per Nr+1 cycles.
//  - done is high for exactly one cycle. out is held unchanged until the next done or rst.
//  - ready = (FSM==IDLE), combinational from the state register.
//  - ready=1 in the same cycle as done, so back-to-back start is accepted there with no
//    bubble beyond the accept cycle.
//  - start while busy (ready=0) is ignored: no queuing, no effect on the current block.
//  - in is sampled only at the accept edge and may change afterwards.
//  - word must be held stable from the accept edge through the done cycle. The core does
//    not register the schedule.
//  - rst asserted mid-block: the block is aborted, no done is produced, out returns to 0.
//  - Counter width = $clog2(Nr+1). The counter never exceeds Nr and never wraps.
//  - All GF(2^8) arithmetic is mod x^8+x^4+x^3+x+1. MixColumns uses the {02,03,01,01}
//    circulant.
// STRUCTURE
//  - aes_pkg (shared): AES_BLOCK_W=128; function nr_of(Nk)=Nk+6; FSM state enum
//    {IDLE,ROUND}; xtime/gmul helpers. The decipher core uses the same package.
//  - Sub-module aes_enc_round(state_in, rk, last, state_out): SubBytes->ShiftRows->
//    [MixColumns bypassed when last=1]->AddRoundKey. Built from the team's existing
//    subBytes/shiftRows/mixColumns/addRoundKey leaves.
//  - Top level holds the FSM, round counter, state register, the round-key mux
//    word[128*cnt +: 128], and the out/done registers.
// TESTING
//  - FIPS-197 App.C.1: in=00112233445566778899aabbccddeeff, schedule of key
//    000102030405060708090a0b0c0d0e0f.
//    -> done 10 cycles after the accept edge, out=69c4e0d86a7b0430d8cdb78070b4c55a.
//  - FIPS-197 App.B: in=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c
//    -> out=3925841d02dc09fbdc118597196a0b32; done high exactly one cycle; out held after.
//  - Back-to-back: start held high across both vectors.
//    -> second accept in the done cycle of the first; two done pulses 11 cycles apart;
//    both outputs correct.
//  - Busy start: pulse start with a different in at cycle 5 of a block
//    -> ignored, ready stays 0, ciphertext is unchanged.
//  - Reset mid-block: rst=1 at round 4 -> next cycle out=0, done=0, ready=1;
//    no done is produced for the aborted block.
//  - Nr=14 / Nk=8 build: key 000102..1e1f, in=00112233445566778899aabbccddeeff
//    -> out=8ea2b7ca516745bfeafc49904b496089 after 14 cycles.

Source files
------------

// File: rtl/aes_cipher_iter_pkg.sv
// Shared AES definitions: block width, round-count helper, FSM states and the
// byte-level transforms (SubBytes, ShiftRows, MixColumns) used by the round logic.
package aes_cipher_iter_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } state_e;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  // Forward S-box; the entry for input 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[8*(255 - int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [AES_BLOCK_W-1:0] sub_bytes(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox(s[8*k +: 8]);
    return r;
  endfunction

  // Byte k lives at s[8*(15-k) +: 8]; row = k%4, column = k/4.
  function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[8*(15 - (rw + 4*c)) +: 8] = s[8*(15 - (rw + 4*((c + rw) % 4))) +: 8];
    return r;
  endfunction

  function automatic logic [AES_BLOCK_W-1:0] mix_columns(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15 - 4*c) +: 8];
      a1 = s[8*(14 - 4*c) +: 8];
      a2 = s[8*(13 - 4*c) +: 8];
      a3 = s[8*(12 - 4*c) +: 8];
      r[8*(15 - 4*c) +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[8*(14 - 4*c) +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[8*(13 - 4*c) +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[8*(12 - 4*c) +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// Host-side bundle of the iterative cipher: launch request, plaintext, key schedule,
// and the registered ciphertext with its completion pulse.
interface aes_cipher_iter_if
  import aes_cipher_iter_pkg::*;
#(
  parameter int NR = 10
) ();
  // start is taken only in a cycle where ready=1 (accept = start & ready at posedge);
  // done pulses one cycle when out carries a new ciphertext, and out holds until the next done.
  logic                            start;
  logic [AES_BLOCK_W-1:0]          in;
  logic [AES_BLOCK_W*(NR+1)-1:0]   word;
  logic                            ready;
  logic [AES_BLOCK_W-1:0]          out;
  logic                            done;

  modport master (output start, in, word, input ready, out, done);
  modport slave  (input start, in, word, output ready, out, done);
endinterface

// File: rtl/aes_cipher_iter_enc_round.sv
// One forward AES round; the final round skips MixColumns.
module aes_enc_round
  import aes_cipher_iter_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_i,
  input  logic [AES_BLOCK_W-1:0] rk_i,
  input  logic                   last_i,
  output logic [AES_BLOCK_W-1:0] state_o
);
  logic [AES_BLOCK_W-1:0] sr;

  assign sr      = shift_rows(sub_bytes(state_i));
  assign state_o = (last_i ? sr : mix_columns(sr)) ^ rk_i;
endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption: initial AddRoundKey at accept, then one round per clock
// against the caller-held expanded key schedule.
module aes_cipher_iter
  import aes_cipher_iter_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nk = N / 32,
  parameter int Nr = nr_of(Nk)
) (
  input  logic             clk,
  input  logic             rst,
  aes_cipher_iter_if.slave bus,
  output state_e           dbg_state_o
);
  localparam int CW = $clog2(Nr + 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AES_BLOCK_W-1:0] st_q, st_d;
  logic [AES_BLOCK_W-1:0] out_q, out_d;
  logic                   done_q, done_d;
  logic [AES_BLOCK_W-1:0] rk;
  logic [AES_BLOCK_W-1:0] round_out;
  logic                   last;

  // The schedule is not registered; the round key is muxed straight off the port.
  assign rk   = bus.word[AES_BLOCK_W*int'(cnt_q) +: AES_BLOCK_W];
  assign last = (cnt_q == CW'(Nr));

  aes_enc_round u_round (
    .state_i (st_q),
    .rk_i    (rk),
    .last_i  (last),
    .state_o (round_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          st_d    = bus.in ^ bus.word[AES_BLOCK_W-1:0];
          cnt_d   = CW'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (last) begin
          out_d   = round_out;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          st_d  = round_out;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.out     = out_q;
  assign bus.done    = done_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for the iterative cipher: AES-128 and AES-256 instances checked against
// FIPS-197 vectors and a byte-matrix reference model with its own key expansion.
module tb_aes_cipher_iter;
  import aes_cipher_iter_pkg::*;

  localparam int W  = 128;
  localparam int SW = 128 * 15;

  logic clk;
  logic rst;
  logic rst_q = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  aes_cipher_iter_if #(.NR(10)) bus10 ();
  aes_cipher_iter_if #(.NR(14)) bus14 ();
  state_e dbg10, dbg14;

  aes_cipher_iter #(.N(128), .Nk(4), .Nr(10)) u_dut10 (
    .clk(clk), .rst(rst), .bus(bus10), .dbg_state_o(dbg10)
  );
  aes_cipher_iter #(.N(256), .Nk(8), .Nr(14)) u_dut14 (
    .clk(clk), .rst(rst), .bus(bus14), .dbg_state_o(dbg14)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  // key holds nk words left-aligned in 256 bits
  function automatic logic [SW-1:0] expand_key(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [SW-1:0] s;
    int            nr;
    nr = nk + 6; rc = 8'h01; s = '0;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = key[255 - 32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gf_mul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) s[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  function automatic logic [W-1:0] ref_encrypt(input logic [W-1:0] pt, input logic [SW-1:0] sched,
                                               input int nr);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [W-1:0] res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127 - 8*(r + 4*c) -: 8] ^ sched[127 - 8*(r + 4*c) -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_t[s[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < nr)
            s[r][c] = gf_mul(8'h02, t[r][c]) ^ gf_mul(8'h03, t[(r+1)%4][c])
                      ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = s[r][c] ^ sched[128*rnd + 127 - 8*(r + 4*c) -: 8];
    end
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127 - 8*(r + 4*c) -: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q10[$];
  logic [W-1:0] exp_q14[$];
  int           exp_cyc_q10[$];
  int           exp_cyc_q14[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s @cyc %0d: got %s", name, cyc, what);
  endtask

  logic [W-1:0] held10 = '0;
  logic [W-1:0] held14 = '0;
  logic         prev_done10 = 1'b0;
  logic         prev_done14 = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    int           c;
    if (rst_q) begin
      check("rst_out10", bus10.out, '0);
      check("rst_done10", W'(bus10.done), '0);
      check("rst_ready10", W'(bus10.ready), W'(1));
      held10 = '0;
      prev_done10 = 1'b0;
    end else if (!rst) begin
      if (bus10.done) begin
        check("done_pulse10", W'(prev_done10), '0);
        check("ready_at_done10", W'(bus10.ready), W'(1));
        if (exp_q10.size() == 0) fail_event("unexpected_done10", "done with nothing outstanding");
        else begin
          e = exp_q10.pop_front();
          c = exp_cyc_q10.pop_front();
          check("cipher10", bus10.out, e);
          check("latency10", W'(cyc), W'(c));
          held10 = e;
        end
      end else check("hold10", bus10.out, held10);
      prev_done10 = bus10.done;
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    int           c;
    if (rst_q) begin
      check("rst_out14", bus14.out, '0);
      check("rst_done14", W'(bus14.done), '0);
      check("rst_ready14", W'(bus14.ready), W'(1));
      held14 = '0;
      prev_done14 = 1'b0;
    end else if (!rst) begin
      if (bus14.done) begin
        check("done_pulse14", W'(prev_done14), '0);
        check("ready_at_done14", W'(bus14.ready), W'(1));
        if (exp_q14.size() == 0) fail_event("unexpected_done14", "done with nothing outstanding");
        else begin
          e = exp_q14.pop_front();
          c = exp_cyc_q14.pop_front();
          check("cipher14", bus14.out, e);
          check("latency14", W'(cyc), W'(c));
          held14 = e;
        end
      end else check("hold14", bus14.out, held14);
      prev_done14 = bus14.done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int sel, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < 64) begin
      @(negedge clk);
      ok = (sel == 10) ? bus10.ready : bus14.ready;
      i++;
    end
  endtask

  task automatic issue(input int sel, input logic [W-1:0] pt, input logic [SW-1:0] sched,
                       output int acc_cyc, output bit ok);
    wait_ready(sel, ok);
    acc_cyc = -1;
    if (!ok) begin
      fail_event("ready_wait", "ready timeout");
      return;
    end
    if (sel == 10) begin
      bus10.in = pt; bus10.word = sched[128*11-1:0]; bus10.start = 1'b1;
    end else begin
      bus14.in = pt; bus14.word = sched[128*15-1:0]; bus14.start = 1'b1;
    end
    @(posedge clk);
    #1;
    bus10.start = 1'b0;
    bus14.start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic launch(input int sel, input logic [W-1:0] pt, input logic [SW-1:0] sched,
                        input logic [W-1:0] exp_ct);
    int a;
    bit ok;
    issue(sel, pt, sched, a, ok);
    if (ok) begin
      if (sel == 10) begin exp_q10.push_back(exp_ct); exp_cyc_q10.push_back(a + 10); end
      else           begin exp_q14.push_back(exp_ct); exp_cyc_q14.push_back(a + 14); end
    end
  endtask

  // ---------------- stimulus ----------------
  localparam logic [W-1:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [W-1:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [W-1:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic [W-1:0]  pt;
    logic [255:0]  key;
    logic [SW-1:0] sched_c, sched_b, sched;
    int            a;
    bit            ok;

    rst = 1'b1;
    bus10.start = 1'b0; bus10.in = '0; bus10.word = '0;
    bus14.start = 1'b0; bus14.in = '0; bus14.word = '0;
    build_sbox();
    sched_c = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    sched_b = expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    launch(10, PT_C, sched_c, CT_C);
    launch(10, PT_B, sched_b, CT_B);

    // start held high across two blocks: second accept lands in the first done cycle
    wait_ready(10, ok);
    if (!ok) fail_event("b2b_ready", "ready timeout");
    else begin
      bus10.in = PT_C; bus10.word = sched_c[128*11-1:0]; bus10.start = 1'b1;
      @(posedge clk);
      #1;
      a = cyc;
      exp_q10.push_back(CT_C); exp_cyc_q10.push_back(a + 10);
      exp_q10.push_back(CT_B); exp_cyc_q10.push_back(a + 21);
      bus10.in = PT_B;
      repeat (10) @(posedge clk);
      #1;
      bus10.word = sched_b[128*11-1:0];
      @(posedge clk);
      #1;
      bus10.start = 1'b0;
    end

    // start pulsed while busy must be ignored
    pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
    key   = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    sched = expand_key(key, 4);
    launch(10, pt, sched, ref_encrypt(pt, sched, 10));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("busy_ready10", W'(bus10.ready), '0);
    check("busy_state10", W'(dbg10), W'(ROUND));
    bus10.in = ~pt;
    bus10.start = 1'b1;
    @(posedge clk);
    #1 bus10.start = 1'b0;
    @(negedge clk);
    check("busy_ready_after10", W'(bus10.ready), '0);

    // reset in round 4 aborts the block with no done
    pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
    sched = expand_key({$urandom(), $urandom(), $urandom(), $urandom(), 128'h0}, 4);
    issue(10, pt, sched, a, ok);
    if (ok) begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
    end
    repeat (20) @(posedge clk);

    for (int v = 0; v < 8; v++) begin
      pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
      key   = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
      sched = expand_key(key, 4);
      launch(10, pt, sched, ref_encrypt(pt, sched, 10));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    sched = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    launch(14, PT_C, sched, 128'h8ea2b7ca516745bfeafc49904b496089);
    for (int v = 0; v < 4; v++) begin
      pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
      key   = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
      sched = expand_key(key, 8);
      launch(14, pt, sched, ref_encrypt(pt, sched, 14));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int i = 0; i < 100 && (exp_q10.size() != 0 || exp_q14.size() != 0); i++) @(negedge clk);
    if (exp_q10.size() != 0 || exp_q14.size() != 0) fail_event("drain", "outstanding blocks never completed");
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
